// File: rtl/traffic_lights_monitor.sv
// rtl/traffic_lights_monitor.sv - safety checker on the four light buses; latches faults and requests flash mode
module traffic_lights_monitor #(
  parameter logic [31:0] MIN_YELLOW = 32'd150_000_000,
  parameter logic [31:0] MAX_HOLD   = 32'd3_000_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light_N,
  input  logic [2:0] light_S,
  input  logic [2:0] light_E,
  input  logic [2:0] light_W,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_en,
  output logic [7:0] fault_cnt
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
  localparam logic [2:0] CODE_CONFLICT = 3'd2;
  localparam logic [2:0] CODE_BAD_SEQ  = 3'd3;
  localparam logic [2:0] CODE_SHORT_Y  = 3'd4;
  localparam logic [2:0] CODE_WATCHDOG = 3'd5;

  // Direction slices in the packed light vectors: N=0, S=1, E=2, W=3.
  logic [11:0] cur_q, prev_q;
  logic [31:0] yel_q [4];
  logic [31:0] yel_d [4];
  logic [31:0] wd_q, wd_d;
  state_t      state_q, state_d;
  logic        fault_q, fault_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        clr_cnt;
  logic        hit_ill, hit_conf, hit_bad, hit_short, hit_wd;
  logic [2:0]  hit_code;

  // Sample the light buses and keep the previous sample for transition checks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= {RED, RED, RED, RED};
      prev_q <= {RED, RED, RED, RED};
    end else begin
      cur_q  <= {light_W, light_E, light_S, light_N};
      prev_q <= cur_q;
    end
  end

  // Combinational rule evaluation on cur/prev, reduced to the lowest-numbered cause.
  always_comb begin
    hit_ill   = 1'b0;
    hit_bad   = 1'b0;
    hit_short = 1'b0;
    hit_code  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!(cur_q[3*i +: 3] == GREEN || cur_q[3*i +: 3] == YELLOW || cur_q[3*i +: 3] == RED))
        hit_ill = 1'b1;
      if ((prev_q[3*i +: 3] == GREEN  && cur_q[3*i +: 3] == RED)    ||
          (prev_q[3*i +: 3] == RED    && cur_q[3*i +: 3] == YELLOW) ||
          (prev_q[3*i +: 3] == YELLOW && cur_q[3*i +: 3] == GREEN))
        hit_bad = 1'b1;
      if (prev_q[3*i +: 3] == YELLOW && cur_q[3*i +: 3] == RED && yel_q[i] < MIN_YELLOW)
        hit_short = 1'b1;
    end
    hit_conf = (|cur_q[1:0] | |cur_q[4:3]) & (|cur_q[7:6] | |cur_q[10:9]);
    hit_wd   = (wd_q == MAX_HOLD);
    if (hit_ill)        hit_code = CODE_ILLEGAL;
    else if (hit_conf)  hit_code = CODE_CONFLICT;
    else if (hit_bad)   hit_code = CODE_BAD_SEQ;
    else if (hit_short) hit_code = CODE_SHORT_Y;
    else if (hit_wd)    hit_code = CODE_WATCHDOG;
  end

  // Next state and fault outputs; checks only act in RUN, clear only acts in FAULT.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    clr_cnt = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (hit_code != 3'd0) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = hit_code;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      ST_FAULT: begin
        if (clr_fault) begin
          state_d = ST_INIT;
          fault_d = 1'b0;
          code_d  = 3'd0;
          clr_cnt = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Yellow-duration and no-change watchdog counters, both saturating.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (clr_cnt)
        yel_d[i] = 32'd0;
      else if (cur_q[3*i +: 3] == YELLOW)
        yel_d[i] = (yel_q[i] >= MIN_YELLOW) ? yel_q[i] : yel_q[i] + 32'd1;
      else
        yel_d[i] = 32'd0;
    end
    if (clr_cnt || cur_q != prev_q)
      wd_d = 32'd0;
    else
      wd_d = (wd_q >= MAX_HOLD) ? wd_q : wd_q + 32'd1;
  end

  // State, fault and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      cnt_q   <= 8'd0;
      wd_q    <= 32'd0;
      for (int i = 0; i < 4; i++) yel_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      for (int i = 0; i < 4; i++) yel_q[i] <= yel_d[i];
    end
  end

  assign fault      = fault_q;
  assign flash_en   = fault_q;
  assign fault_code = code_q;
  assign fault_cnt  = cnt_q;

endmodule

// File: tb/tb_traffic_lights_monitor.sv
// tb/tb_traffic_lights_monitor.sv - directed self-checking bench for traffic_lights_monitor
module tb_traffic_lights_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] light_N = R, light_S = R, light_E = R, light_W = R;
  logic       clr_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_en;
  logic [7:0] fault_cnt;

  int n_checks = 0;
  int n_fail = 0;

  traffic_lights_monitor #(.MIN_YELLOW(32'd4), .MAX_HOLD(32'd20)) dut (
    .clk(clk), .rst_n(rst_n),
    .light_N(light_N), .light_S(light_S), .light_E(light_E), .light_W(light_W),
    .clr_fault(clr_fault), .fault(fault), .fault_code(fault_code),
    .flash_en(flash_en), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_l(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e, input logic [2:0] w);
    light_N = n; light_S = s; light_E = e; light_W = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_fault = 1'b0;
    set_l(R, R, R, R);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drives full legal light cycles; returns how many sampled cycles showed fault set.
  task automatic run_legal(input int rounds, output int bad);
    logic [11:0] tbl [4];
    int          len [4];
    tbl[0] = {G, G, R, R}; len[0] = 10;
    tbl[1] = {Y, Y, R, R}; len[1] = 4;
    tbl[2] = {R, R, G, G}; len[2] = 10;
    tbl[3] = {R, R, Y, Y}; len[3] = 4;
    bad = 0;
    for (int r = 0; r < rounds; r++)
      for (int p = 0; p < 4; p++) begin
        set_l(tbl[p][11:9], tbl[p][8:6], tbl[p][5:3], tbl[p][2:0]);
        for (int c = 0; c < len[p]; c++) begin
          tick();
          if (fault !== 1'b0) bad++;
        end
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_l(R, R, R, R);
    tick();
    n_checks++;
    if ({fault, flash_en, fault_code, fault_cnt} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 0", {fault, flash_en, fault_code, fault_cnt});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init_fault got %b want 0", fault);
    end
  endtask

  task automatic test_legal_cycle();
    int bad;
    do_reset();
    run_legal(2, bad);
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL legal_no_fault got %0d faulty cycles want 0", bad);
    end
    n_checks++;
    if (fault_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL legal_cnt got %0d want 0", fault_cnt);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    tick();
    tick();
    set_l(Y, R, G, R);
    tick();
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_edge1 got %b want 0", fault);
    end
    tick();
    n_checks++;
    if ({fault, flash_en, fault_code, fault_cnt} !== {1'b1, 1'b1, 3'd2, 8'd1}) begin
      n_fail++;
      $display("FAIL conflict_edge2 got f=%b fl=%b c=%0d n=%0d want 1 1 2 1", fault, flash_en, fault_code, fault_cnt);
    end
  endtask

  task automatic test_short_yellow_clear();
    do_reset();
    set_l(G, G, R, R);
    repeat (3) tick();
    set_l(Y, G, R, R);
    repeat (3) tick();
    set_l(R, G, R, R);
    tick();
    tick();
    n_checks++;
    if ({fault, fault_code, fault_cnt} !== {1'b1, 3'd4, 8'd1}) begin
      n_fail++;
      $display("FAIL short_yellow got f=%b c=%0d n=%0d want 1 4 1", fault, fault_code, fault_cnt);
    end
    repeat (2) tick();
    n_checks++;
    if ({fault, fault_code} !== {1'b1, 3'd4}) begin
      n_fail++;
      $display("FAIL fault_hold got f=%b c=%0d want 1 4", fault, fault_code);
    end
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    n_checks++;
    if ({fault, flash_en, fault_code, fault_cnt} !== {1'b0, 1'b0, 3'd0, 8'd1}) begin
      n_fail++;
      $display("FAIL clear got f=%b fl=%b c=%0d n=%0d want 0 0 0 1", fault, flash_en, fault_code, fault_cnt);
    end
    tick();
    tick();
    set_l(R, G, G, R);
    tick();
    tick();
    n_checks++;
    if ({fault, fault_code, fault_cnt} !== {1'b1, 3'd2, 8'd2}) begin
      n_fail++;
      $display("FAIL second_fault got f=%b c=%0d n=%0d want 1 2 2", fault, fault_code, fault_cnt);
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_l(G, G, R, R);
    repeat (3) tick();
    set_l(R, G, 3'b111, R);
    tick();
    tick();
    n_checks++;
    if ({fault, fault_code, fault_cnt} !== {1'b1, 3'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL priority got f=%b c=%0d n=%0d want 1 1 1", fault, fault_code, fault_cnt);
    end
  endtask

  task automatic test_watchdog();
    int cycles;
    do_reset();
    cycles = 0;
    while (fault !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != 21) begin
      n_fail++;
      $display("FAIL watchdog_latency got %0d edges want 21", cycles);
    end
    n_checks++;
    if ({fault, fault_code, fault_cnt} !== {1'b1, 3'd5, 8'd1}) begin
      n_fail++;
      $display("FAIL watchdog_code got f=%b c=%0d n=%0d want 1 5 1", fault, fault_code, fault_cnt);
    end
    set_l(3'b111, R, R, R);
    repeat (3) tick();
    set_l(Y, G, G, R);
    repeat (3) tick();
    n_checks++;
    if ({fault, fault_code, fault_cnt} !== {1'b1, 3'd5, 8'd1}) begin
      n_fail++;
      $display("FAIL fault_ignore got f=%b c=%0d n=%0d want 1 5 1", fault, fault_code, fault_cnt);
    end
  endtask

  task automatic test_reset_in_fault();
    int bad;
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_fault got %b want 1", fault);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fault, flash_en, fault_code, fault_cnt} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset got %b want 0", {fault, flash_en, fault_code, fault_cnt});
    end
    set_l(R, R, R, R);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    run_legal(1, bad);
    n_checks++;
    if (bad != 0 || fault_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_legal got bad=%0d n=%0d want 0 0", bad, fault_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_short_yellow_clear();
    test_priority();
    test_watchdog();
    test_reset_in_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_lights_monitor.md
TRAFFIC_LIGHTS_MONITOR -- requirements
Module: traffic_lights_monitor
Downstream safety checker on the four light buses produced by traffic_lights_system; latches faults and requests flash mode.

Interface
REQ-001 SHALL have parameter MIN_YELLOW, default 32'd150_000_000, meaning minimum yellow duration in clk cycles (3 s @ 50 MHz).
REQ-002 SHALL have parameter MAX_HOLD, default 32'd3_000_000_000, meaning watchdog limit in clk cycles with no change on any light bit.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain for the whole block.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports light_N, light_S, light_E, light_W  input  3 each  lamp state: [2]=red, [1]=yellow, [0]=green.
REQ-006 SHALL have port clr_fault  input  1  synchronous, level-sampled fault clear/re-arm.
REQ-007 SHALL have port fault  output  1  latched fault flag.
REQ-008 SHALL have port fault_code  output  3  cause of first latched fault.
REQ-009 SHALL have port flash_en  output  1  flash-mode request to the lamp driver; equals fault.
REQ-010 SHALL have port fault_cnt  output  8  count of faults latched since reset, saturating at 255.

Function
REQ-011 SHALL register all 12 light bits into cur every cycle, and copy cur into prev every cycle.
REQ-012 SHALL implement FSM states INIT, RUN, FAULT.
REQ-013 INIT SHALL last exactly one cycle (prev invalid), then move to RUN; no sequence, yellow or watchdog checks are made in INIT.
REQ-014 In RUN, checks SHALL evaluate cur/prev combinationally; a hit registers fault=1 at the next edge, i.e. fault rises on the 2nd rising edge after the offending input value is presented.
REQ-015 Code 1 ILLEGAL: any direction in cur not one-hot (000, or more than one bit set).
REQ-016 Code 2 CONFLICT: (N or S green/yellow) while (E or W green/yellow) in cur.
REQ-017 Code 3 BAD_SEQ: any direction with prev->cur green->red, red->yellow, or yellow->green.
REQ-018 Code 4 SHORT_YELLOW: a direction goes yellow->red with its yellow counter < MIN_YELLOW.
REQ-019 Code 5 WATCHDOG: watchdog counter reaches MAX_HOLD.
REQ-020 Codes 0, 6 and 7 are unused; fault_code SHALL read 0 while no fault is latched.
REQ-021 When several faults occur in one cycle, the lowest code SHALL be latched.
REQ-022 Each direction SHALL have a 32-bit yellow counter: cleared when cur is not yellow, incremented each cycle cur is yellow, saturating at MIN_YELLOW.
REQ-023 The 32-bit watchdog counter SHALL clear when cur != prev (any bit), else increment, saturating at MAX_HOLD.
REQ-024 RUN->FAULT on any hit: set fault and flash_en, load fault_code, increment fault_cnt (saturating at 255).
REQ-025 In FAULT, outputs SHALL hold and further hits SHALL be ignored (no code overwrite, no count).
REQ-026 In FAULT with clr_fault=1: next state INIT; fault, flash_en and fault_code clear; yellow and watchdog counters clear; fault_cnt holds. Clear wins over any simultaneous hit.
REQ-027 clr_fault SHALL be ignored in INIT and RUN.

Reset
REQ-028 rst_n low SHALL immediately force: state INIT, fault=0, flash_en=0, fault_code=0, fault_cnt=0, all counters 0, cur and prev 3'b100 on all directions.
REQ-029 Reset asserted mid-operation, including in FAULT, SHALL abort all state with no residual fault.
REQ-030 After rst_n rises, the first clk edge SHALL enter INIT behaviour (REQ-013).

Verification (MIN_YELLOW=4, MAX_HOLD=20)
REQ-031 Legal cycle N/S green 10 cyc -> yellow 4 -> red; E/W mirrored -> fault stays 0 and fault_cnt stays 0 throughout.
REQ-032 light_N=010 while light_E=001 -> fault=1, fault_code=2, flash_en=1 at the 2nd edge; fault_cnt=1.
REQ-033 N yellow for 3 cycles then red -> fault_code=4. Then clr_fault pulse -> fault=0 next edge; fault_cnt stays 1.
REQ-034 N green->red directly while light_E=111 in the same cycle -> fault_code=1 (priority), fault_cnt=1.
REQ-035 All lights frozen for 20 cycles after INIT -> fault_code=5. Further violations in FAULT -> code and count unchanged.
REQ-036 rst_n pulled low while in FAULT -> all outputs 0 asynchronously. After release, a legal sequence -> no fault.
